pipeline_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives stall/flush controls into every inter-stage register: F/D (Stall), D/E, E/M, M/W.
- Generates E-stage forwarding selects.
- Sequences multi-cycle load-use stalls and data-memory wait states, and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Hazard-control bundle between the 5-stage datapath and pipeline_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE0, RegWriteE, PCSrcE;
    logic        RegWriteM, RegWriteW;
    logic        dmem_req, dmem_ready;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] stall_cnt, flush_cnt;
    logic        err;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, RegWriteE, PCSrcE, RegWriteM, RegWriteW,
        output dmem_req, dmem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, stall_cnt, flush_cnt, err
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, RegWriteE, PCSrcE, RegWriteM, RegWriteW,
        input  dmem_req, dmem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, stall_cnt, flush_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush/forwarding controller for a 5-stage RISC-V pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  c_ld_init  = 4'(LOAD_LAT - 1);
    localparam logic [15:0] c_timeout  = 16'(MEM_TIMEOUT);
    localparam bit          c_multi_ld = (LOAD_LAT > 1);

    state_t      r_state;
    state_t      r_ret_state;
    state_t      w_eff_state;
    logic [3:0]  r_ld_cnt;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        r_err;

    logic        w_lu_hazard;
    logic        w_mem_wait;
    logic        w_stall_fd;
    logic        w_stall_em;
    logic        w_flush_d;
    logic        w_flush_e;
    logic        w_flush_w;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_lu_hazard = bus.ResultSrcE0 && bus.RegWriteE && (bus.RdE != 5'd0) &&
                         ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    assign w_mem_wait  = bus.dmem_req && !bus.dmem_ready;

    // While waiting on memory, the cycle that releases the wait follows the interrupted state's rules.
    assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

    always_comb begin
        w_stall_fd = 1'b0;
        w_stall_em = 1'b0;
        w_flush_d  = 1'b0;
        w_flush_e  = 1'b0;
        w_flush_w  = 1'b0;
        if (w_mem_wait) begin
            w_stall_fd = 1'b1;
            w_stall_em = 1'b1;
            w_flush_w  = 1'b1;
        end else if (bus.PCSrcE) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
        end else if (w_eff_state == LD_STALL || w_lu_hazard) begin
            w_stall_fd = 1'b1;
            w_flush_e  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_ld_cnt    <= '0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_stall_fd)
                r_stall_cnt <= r_stall_cnt + 32'd1;

            if (w_mem_wait) begin
                r_state <= MEM_WAIT;
                if (r_state != MEM_WAIT)
                    r_ret_state <= r_state;
                // Counter saturates at the timeout so it can never wrap back below it.
                if (r_wait_cnt != c_timeout) begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                    if (r_wait_cnt + 16'd1 == c_timeout)
                        r_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
                if (bus.PCSrcE) begin
                    r_state     <= RUN;
                    r_ld_cnt    <= '0;
                    r_flush_cnt <= r_flush_cnt + 32'd1;
                end else if (w_eff_state == LD_STALL) begin
                    if (r_ld_cnt <= 4'd1) begin
                        r_state  <= RUN;
                        r_ld_cnt <= '0;
                    end else begin
                        r_state  <= LD_STALL;
                        r_ld_cnt <= r_ld_cnt - 4'd1;
                    end
                end else if (w_lu_hazard && c_multi_ld) begin
                    r_state  <= LD_STALL;
                    r_ld_cnt <= c_ld_init;
                end else begin
                    r_state  <= RUN;
                end
            end
        end
    end

    assign bus.StallF    = w_stall_fd & ~rst;
    assign bus.StallD    = w_stall_fd & ~rst;
    assign bus.StallE    = w_stall_em & ~rst;
    assign bus.StallM    = w_stall_em & ~rst;
    assign bus.FlushD    = w_flush_d  & ~rst;
    assign bus.FlushE    = w_flush_e  & ~rst;
    assign bus.FlushW    = w_flush_w  & ~rst;
    assign bus.ForwardAE = rst ? 2'b00 :
                           fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
    assign bus.ForwardBE = rst ? 2'b00 :
                           fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Self-checking bench for pipeline_ctrl (LOAD_LAT=1 and LOAD_LAT=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipeline_ctrl_if if0 ();
    pipeline_ctrl_if if1 ();

    // Instance 0: LOAD_LAT=1, default timeout. Instance 1: LOAD_LAT=3, MEM_TIMEOUT=4.
    pipeline_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(255)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    pipeline_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(4))   u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    assign if1.Rs1D        = if0.Rs1D;
    assign if1.Rs2D        = if0.Rs2D;
    assign if1.Rs1E        = if0.Rs1E;
    assign if1.Rs2E        = if0.Rs2E;
    assign if1.RdE         = if0.RdE;
    assign if1.RdM         = if0.RdM;
    assign if1.RdW         = if0.RdW;
    assign if1.ResultSrcE0 = if0.ResultSrcE0;
    assign if1.RegWriteE   = if0.RegWriteE;
    assign if1.PCSrcE      = if0.PCSrcE;
    assign if1.RegWriteM   = if0.RegWriteM;
    assign if1.RegWriteW   = if0.RegWriteW;
    assign if1.dmem_req    = if0.dmem_req;
    assign if1.dmem_ready  = if0.dmem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding load-stall cycles owed, current wait run length, counters.
    int          m_hold [2];
    int          m_wait [2];
    logic        m_err  [2];
    logic [31:0] m_scnt [2];
    logic [31:0] m_fcnt [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int tmo_of(input int i);
        return (i == 0) ? 255 : 4;
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (if0.RegWriteM && if0.RdM != 0 && if0.RdM == rs) return 2'b10;
        if (if0.RegWriteW && if0.RdW != 0 && if0.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_lu();
        return if0.ResultSrcE0 && if0.RegWriteE && if0.RdE != 0 &&
               (if0.RdE == if0.Rs1D || if0.RdE == if0.Rs2D);
    endfunction

    function automatic logic ref_mw();
        return if0.dmem_req && !if0.dmem_ready;
    endfunction

    // Packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
    function automatic logic [10:0] exp_out(input int i);
        logic [10:0] r;
        r = '0;
        if (rst) return r;
        r[3:2] = ref_fwd(if0.Rs1E);
        r[1:0] = ref_fwd(if0.Rs2E);
        if (ref_mw())                      r[10:4] = 7'b1111001;
        else if (if0.PCSrcE)               r[10:4] = 7'b0000110;
        else if (m_hold[i] > 0 || ref_lu()) r[10:4] = 7'b1100010;
        return r;
    endfunction

    task automatic model_edge(input int i);
        logic [10:0] o;
        o = exp_out(i);
        if (o[10]) m_scnt[i] = m_scnt[i] + 1;
        if (ref_mw()) begin
            m_wait[i] = m_wait[i] + 1;
            if (m_wait[i] == tmo_of(i)) m_err[i] = 1'b1;
        end else begin
            m_wait[i] = 0;
            if (if0.PCSrcE) begin
                m_hold[i] = 0;
                m_fcnt[i] = m_fcnt[i] + 1;
            end else if (m_hold[i] > 0) begin
                m_hold[i] = m_hold[i] - 1;
            end else if (ref_lu()) begin
                m_hold[i] = lat_of(i) - 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 0;
            m_wait[i] = 0;
            m_err[i]  = 1'b0;
            m_scnt[i] = '0;
            m_fcnt[i] = '0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("outs0", {21'd0, if0.StallF, if0.StallD, if0.StallE, if0.StallM, if0.FlushD,
                      if0.FlushE, if0.FlushW, if0.ForwardAE, if0.ForwardBE}, {21'd0, exp_out(0)});
        chk("outs1", {21'd0, if1.StallF, if1.StallD, if1.StallE, if1.StallM, if1.FlushD,
                      if1.FlushE, if1.FlushW, if1.ForwardAE, if1.ForwardBE}, {21'd0, exp_out(1)});
        chk("scnt0", if0.stall_cnt, m_scnt[0]);
        chk("scnt1", if1.stall_cnt, m_scnt[1]);
        chk("fcnt0", if0.flush_cnt, m_fcnt[0]);
        chk("fcnt1", if1.flush_cnt, m_fcnt[1]);
        chk("err0",  {31'd0, if0.err}, {31'd0, m_err[0]});
        chk("err1",  {31'd0, if1.err}, {31'd0, m_err[1]});
    endtask

    task automatic step();
        #2;
        check_all();
        if (!rst) begin
            model_edge(0);
            model_edge(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        if0.Rs1D = '0; if0.Rs2D = '0; if0.Rs1E = '0; if0.Rs2E = '0;
        if0.RdE  = '0; if0.RdM  = '0; if0.RdW  = '0;
        if0.ResultSrcE0 = 1'b0; if0.RegWriteE = 1'b0; if0.PCSrcE = 1'b0;
        if0.RegWriteM = 1'b0; if0.RegWriteW = 1'b0;
        if0.dmem_req = 1'b0; if0.dmem_ready = 1'b0;
    endtask

    task automatic load_use_rs1();
        if0.ResultSrcE0 = 1'b1; if0.RegWriteE = 1'b1; if0.RdE = 5'd7; if0.Rs1D = 5'd7;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        clear_in();
        rst = 1'b1;
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Forwarding: M beats W, x0 never forwards
        if0.RdM = 5'd5; if0.RegWriteM = 1'b1; if0.RdW = 5'd5; if0.RegWriteW = 1'b1;
        if0.Rs1E = 5'd5; if0.Rs2E = 5'd0;
        #2;
        chk("fwdA_M", {30'd0, if0.ForwardAE}, 32'd2);
        chk("fwdB_0", {30'd0, if0.ForwardBE}, 32'd0);
        step();
        if0.RdM = 5'd0;
        #2;
        chk("fwdA_W", {30'd0, if1.ForwardAE}, 32'd1);
        step();
        clear_in();

        // Single-cycle load-use hazard
        load_use_rs1();
        #2;
        chk("lu_stallF", {31'd0, if0.StallF}, 32'd1);
        chk("lu_flushE", {31'd0, if1.FlushE}, 32'd1);
        step();
        clear_in();
        #2;
        chk("lu1_release", {31'd0, if0.StallF}, 32'd0);
        chk("lu3_hold",    {31'd0, if1.StallD}, 32'd1);
        repeat (4) step();
        chk("lu1_cnt", if0.stall_cnt, 32'd1);
        chk("lu3_cnt", if1.stall_cnt, 32'd3);

        // Taken branch beats load-use
        if0.PCSrcE = 1'b1; load_use_rs1();
        #2;
        chk("br_flushD", {31'd0, if1.FlushD}, 32'd1);
        chk("br_stallF", {31'd0, if1.StallF}, 32'd0);
        step();
        clear_in();
        step();
        chk("br_fcnt", if1.flush_cnt, 32'd1);
        chk("br_scnt", if1.stall_cnt, 32'd3);

        // Memory wait arriving inside a multi-cycle load stall
        load_use_rs1();
        step();
        clear_in();
        if0.dmem_req = 1'b1; if0.dmem_ready = 1'b0;
        repeat (4) begin
            #1;
            chk("mw_stallM", {31'd0, if1.StallM}, 32'd1);
            step();
        end
        if0.dmem_req = 1'b0;
        repeat (4) step();
        chk("mw_scnt1", if1.stall_cnt, 32'd10);
        chk("mw_scnt0", if0.stall_cnt, 32'd6);

        pulse_reset();

        // Timeout sets a sticky error
        if0.dmem_req = 1'b1; if0.dmem_ready = 1'b0;
        repeat (3) step();
        chk("tmo_pre", {31'd0, if1.err}, 32'd0);
        step();
        chk("tmo_set", {31'd0, if1.err}, 32'd1);
        repeat (2) step();
        if0.dmem_ready = 1'b1;
        step();
        chk("tmo_sticky", {31'd0, if1.err}, 32'd1);
        chk("tmo_inst0",  {31'd0, if0.err}, 32'd0);

        // Asynchronous reset in the middle of a stall
        if0.dmem_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("arst_stallF", {31'd0, if1.StallF}, 32'd0);
        chk("arst_flushW", {31'd0, if1.FlushW}, 32'd0);
        chk("arst_err",    {31'd0, if1.err}, 32'd0);
        chk("arst_scnt",   if1.stall_cnt, 32'd0);
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        clear_in();
        rst = 1'b0;

        // Randomised traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            if0.Rs1D = 5'($urandom_range(0, 7));
            if0.Rs2D = 5'($urandom_range(0, 7));
            if0.Rs1E = 5'($urandom_range(0, 7));
            if0.Rs2E = 5'($urandom_range(0, 7));
            if0.RdE  = 5'($urandom_range(0, 7));
            if0.RdM  = 5'($urandom_range(0, 7));
            if0.RdW  = 5'($urandom_range(0, 7));
            if0.ResultSrcE0 = ($urandom_range(0, 2) == 0);
            if0.RegWriteE   = ($urandom_range(0, 3) != 0);
            if0.RegWriteM   = 1'($urandom_range(0, 1));
            if0.RegWriteW   = 1'($urandom_range(0, 1));
            if0.PCSrcE      = ($urandom_range(0, 9) == 0);
            if0.dmem_req    = ($urandom_range(0, 3) == 0);
            if0.dmem_ready  = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
